// File: rtl/axi_wr_fifo_ctrl_pkg.sv
// Shared async-FIFO constants and Gray/binary helpers, used by both the
// write-side and read-side pointer controllers.
package axi_wr_fifo_ctrl_pkg;

  localparam int unsigned FIFO_ADDR_W_DEF    = 4;
  localparam int unsigned FIFO_AFULL_LVL_DEF = 12;
  localparam int unsigned FIFO_PTR_MAX_W     = 32;

  // Arguments are zero-extended by the caller; the leading zeros leave the result unaffected.
  function automatic logic [FIFO_PTR_MAX_W-1:0] gray2bin(
    input logic [FIFO_PTR_MAX_W-1:0] g
  );
    logic [FIFO_PTR_MAX_W-1:0] b;
    b = '0;
    b[FIFO_PTR_MAX_W-1] = g[FIFO_PTR_MAX_W-1];
    for (int unsigned i = 0; i < FIFO_PTR_MAX_W - 1; i++) begin
      b[FIFO_PTR_MAX_W-2-i] = b[FIFO_PTR_MAX_W-1-i] ^ g[FIFO_PTR_MAX_W-2-i];
    end
    return b;
  endfunction

  function automatic logic [FIFO_PTR_MAX_W-1:0] bin2gray(
    input logic [FIFO_PTR_MAX_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/axi_wr_fifo_ctrl_gen_gray_counter.sv
// Enabled Gray counter with a shadow binary register, so both encodings of
// the pointer come straight from flops.
module gen_gray_counter
  import axi_wr_fifo_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_ADDR_W_DEF + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] bin_o,
  output logic [WIDTH-1:0] gray_o
);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] gray_d;
  logic [WIDTH-1:0] bin_inc;

  always_comb begin
    bin_inc = bin_q + WIDTH'(1);
    bin_d   = bin_q;
    gray_d  = gray_q;
    if (en) begin
      bin_d  = bin_inc;
      gray_d = WIDTH'(bin2gray(FIFO_PTR_MAX_W'(bin_inc)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  assign bin_o  = bin_q;
  assign gray_o = gray_q;

endmodule

// File: rtl/axi_wr_fifo_ctrl.sv
// Write-side controller of an async FIFO: write pointer, read-pointer
// synchronizer, full/almost-full/level status and sticky overflow error.
module axi_wr_fifo_ctrl
  import axi_wr_fifo_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = FIFO_ADDR_W_DEF,
  parameter int unsigned AFULL_LVL = FIFO_AFULL_LVL_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W:0]   rd_ptr_gray,
  input  logic              err_clr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic              ovf_err,
  output logic [ADDR_W:0]   wr_level
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AFULL_CMP = PTR_W'(AFULL_LVL);

  logic [PTR_W-1:0] rd_sync1_q;
  logic [PTR_W-1:0] rd_sync2_q;
  logic [PTR_W-1:0] rd_bin;
  logic [PTR_W-1:0] wr_bin;
  logic             ovf_err_q;
  logic             ovf_err_d;

  gen_gray_counter #(
    .WIDTH (PTR_W)
  ) u_wr_ptr (
    .clk    (clk),
    .reset  (reset),
    .en     (wr_en),
    .bin_o  (wr_bin),
    .gray_o (wr_ptr_gray)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_sync1_q <= '0;
      rd_sync2_q <= '0;
    end else begin
      rd_sync1_q <= rd_ptr_gray;
      rd_sync2_q <= rd_sync1_q;
    end
  end

  // Status is built from the pointer flops and rd_sync2_q only.
  always_comb begin
    rd_bin      = PTR_W'(gray2bin(FIFO_PTR_MAX_W'(rd_sync2_q)));
    wr_level    = wr_bin - rd_bin;
    almost_full = (wr_level >= AFULL_CMP);
    full        = (wr_ptr_gray == {~rd_sync2_q[PTR_W-1 -: 2], rd_sync2_q[PTR_W-3:0]});
  end

  assign wr_en   = wr_req & ~full;
  assign wr_addr = wr_bin[ADDR_W-1:0];

  // Overflow has priority over a simultaneous clear.
  always_comb begin
    ovf_err_d = ovf_err_q;
    if (wr_req && full) begin
      ovf_err_d = 1'b1;
    end else if (err_clr) begin
      ovf_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_err_q <= 1'b0;
    end else begin
      ovf_err_q <= ovf_err_d;
    end
  end

  assign ovf_err = ovf_err_q;

endmodule

// File: tb/tb_axi_wr_fifo_ctrl.sv
// Directed self-checking bench for axi_wr_fifo_ctrl with ADDR_W=4, AFULL_LVL=12.
module tb_axi_wr_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_req;
  logic [4:0] rd_ptr_gray;
  logic       err_clr;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [4:0] wr_ptr_gray;
  logic       full;
  logic       almost_full;
  logic       ovf_err;
  logic [4:0] wr_level;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  axi_wr_fifo_ctrl #(
    .ADDR_W    (4),
    .AFULL_LVL (12)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_req      (wr_req),
    .rd_ptr_gray (rd_ptr_gray),
    .err_clr     (err_clr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_ptr_gray (wr_ptr_gray),
    .full        (full),
    .almost_full (almost_full),
    .ovf_err     (ovf_err),
    .wr_level    (wr_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] tb_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gray"},  32'(wr_ptr_gray), 32'd0);
    chk({tag, "_addr"},  32'(wr_addr),     32'd0);
    chk({tag, "_level"}, 32'(wr_level),    32'd0);
    chk({tag, "_full"},  32'(full),        32'd0);
    chk({tag, "_afull"}, 32'(almost_full), 32'd0);
    chk({tag, "_ovf"},   32'(ovf_err),     32'd0);
  endtask

  initial begin
    logic [4:0] ptr;
    logic [4:0] prev_gray;

    reset       = 1'b1;
    wr_req      = 1'b0;
    rd_ptr_gray = '0;
    err_clr     = 1'b0;

    // Reset state, wr_en follows wr_req while in reset
    step();
    step();
    chk_all_zero("rst");
    chk("rst_wren0", 32'(wr_en), 32'd0);
    wr_req = 1'b1;
    #1;
    chk("rst_wren1", 32'(wr_en), 32'd1);
    wr_req = 1'b0;
    step();
    reset = 1'b0;

    // 16 back-to-back writes against an idle reader
    for (int unsigned i = 0; i < 16; i++) begin
      wr_req = 1'b1;
      #1;
      chk("fill_addr",  32'(wr_addr),     32'(i));
      chk("fill_wren",  32'(wr_en),       32'd1);
      chk("fill_level", 32'(wr_level),    32'(i));
      chk("fill_afull", 32'(almost_full), (i >= 12) ? 32'd1 : 32'd0);
      chk("fill_full",  32'(full),        32'd0);
      step();
    end
    wr_req = 1'b0;
    #1;
    chk("full_flag",  32'(full),        32'd1);
    chk("full_level", 32'(wr_level),    32'd16);
    chk("full_afull", 32'(almost_full), 32'd1);
    chk("full_gray",  32'(wr_ptr_gray), 32'h18);

    // Write attempt while full
    wr_req = 1'b1;
    #1;
    chk("ovf_wren", 32'(wr_en), 32'd0);
    step();
    wr_req = 1'b0;
    #1;
    chk("ovf_set",   32'(ovf_err),     32'd1);
    chk("ovf_gray",  32'(wr_ptr_gray), 32'h18);
    chk("ovf_level", 32'(wr_level),    32'd16);
    step();
    step();
    chk("ovf_sticky", 32'(ovf_err), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ovf_clr", 32'(ovf_err), 32'd0);

    // Clear coinciding with overflow
    wr_req  = 1'b1;
    err_clr = 1'b1;
    step();
    wr_req  = 1'b0;
    err_clr = 1'b0;
    chk("ovf_setwins", 32'(ovf_err), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ovf_clr2", 32'(ovf_err), 32'd0);

    // Read pointer advanced by one: visible after exactly two cycles
    rd_ptr_gray = 5'b00001;
    step();
    chk("rd_lat1_full", 32'(full), 32'd1);
    step();
    chk("rd_lat2_full",  32'(full),        32'd0);
    chk("rd_lat2_level", 32'(wr_level),    32'd15);
    chk("rd_lat2_afull", 32'(almost_full), 32'd1);

    // Drain the reader to match, then 40 writes with the reader tracking
    ptr         = 5'd16;
    rd_ptr_gray = tb_gray(ptr);
    step();
    step();
    chk("drain_level", 32'(wr_level), 32'd0);
    chk("drain_full",  32'(full),     32'd0);
    for (int unsigned i = 0; i < 40; i++) begin
      rd_ptr_gray = tb_gray(ptr);
      wr_req      = 1'b1;
      #1;
      prev_gray = wr_ptr_gray;
      chk("wrap_addr", 32'(wr_addr), 32'(ptr[3:0]));
      chk("wrap_wren", 32'(wr_en),   32'd1);
      step();
      ptr = ptr + 5'd1;
      chk("wrap_gray", 32'(wr_ptr_gray),    32'(tb_gray(ptr)));
      chk("wrap_msb",  32'(wr_ptr_gray[4]), 32'(ptr[4]));
      chk("wrap_1bit", 32'($countones(prev_gray ^ wr_ptr_gray)), 32'd1);
    end
    wr_req      = 1'b0;
    rd_ptr_gray = tb_gray(ptr);
    step();
    step();
    chk("wrap_level", 32'(wr_level), 32'd0);

    // Asynchronous reset in the middle of a burst
    wr_req = 1'b1;
    step();
    step();
    step();
    #3;
    reset       = 1'b1;
    rd_ptr_gray = '0;
    #1;
    chk_all_zero("arst");
    step();
    reset = 1'b0;
    #1;
    chk("arst_addr0", 32'(wr_addr), 32'd0);
    chk("arst_wren",  32'(wr_en),   32'd1);
    step();
    chk("arst_addr1", 32'(wr_addr),     32'd1);
    chk("arst_gray1", 32'(wr_ptr_gray), 32'd1);
    wr_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_wr_fifo_ctrl.md
AXI_WR_FIFO_CTRL -- requirements
Module: axi_wr_fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning the FIFO RAM address width (depth = 2^ADDR_W).
REQ-002 SHALL have parameter AFULL_LVL, default 12, meaning the occupancy at or above which almost_full asserts.
REQ-003 SHALL have port clk, input, 1, the single write-domain clock.
REQ-004 SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-005 SHALL have port wr_req, input, 1, a write request from the AXI slave datapath.
REQ-006 SHALL have port rd_ptr_gray, input, ADDR_W+1, the Gray read pointer from the read domain (asynchronous to clk).
REQ-007 SHALL have port err_clr, input, 1, which clears ovf_err.
REQ-008 SHALL have port wr_en, output, 1, the RAM write strobe.
REQ-009 SHALL have port wr_addr, output, ADDR_W, the RAM write address.
REQ-010 SHALL have port wr_ptr_gray, output, ADDR_W+1, the Gray write pointer exported to the read domain.
REQ-011 SHALL have ports full, almost_full and ovf_err, each output, 1, carrying the status flags.
REQ-012 SHALL have port wr_level, output, ADDR_W+1, the current FIFO occupancy of 0..2^ADDR_W.

Function
REQ-013 SHALL pass rd_ptr_gray through a 2-flop synchronizer (rd_sync) before any use.
REQ-014 SHALL hold the write pointer as an (ADDR_W+1)-bit Gray counter that increments by exactly one code on each cycle where wr_en=1.
REQ-015 SHALL drive wr_en = wr_req & ~full, combinationally, on the same cycle.
REQ-016 SHALL drive wr_addr as the low ADDR_W bits of the binary equivalent of the current write pointer, so that the address applies to the write on that cycle.
REQ-017 SHALL drive wr_ptr_gray directly from the counter flops, with no combinational logic on the output.
REQ-018 SHALL assert full when wr_ptr_gray equals rd_sync with its two MSBs inverted and its remaining bits equal.
REQ-019 SHALL compute wr_level as (wr_bin - rd_bin) mod 2^(ADDR_W+1), where rd_bin is rd_sync converted from Gray to binary.
REQ-020 SHALL assert almost_full when wr_level >= AFULL_LVL.
REQ-021 SHALL derive full, almost_full and wr_level only from registered state, with no path from any input to these outputs.
REQ-022 SHALL set ovf_err on any cycle where wr_req=1 and full=1, keep it set until cleared, and never alter the pointer on such a cycle.
REQ-023 SHALL clear ovf_err on the cycle after err_clr=1; when err_clr and an overflow occur together, set wins.
REQ-024 SHALL wrap the pointer from its all-ones-binary code back to 0 with no gap or stall.
REQ-025 SHALL make a read-pointer change visible in full, almost_full and wr_level exactly 2 cycles after it is stable at the input.
REQ-026 SHALL treat full as pessimistic: it may remain asserted up to 2 cycles after a read, and this is correct behaviour.

Reset
REQ-027 SHALL, on reset, set the write pointer to 0, both synchronizer stages to 0 and ovf_err to 0.
REQ-028 SHALL, during and right after reset, drive wr_ptr_gray=0, wr_addr=0, wr_level=0, full=0, almost_full=0 and ovf_err=0, with wr_en following wr_req.
REQ-029 SHALL abandon any in-flight write when reset asserts mid-operation; the read domain resets concurrently, so no pointer recovery is needed.

Structure
REQ-030 SHALL place the Gray-to-binary conversion function and the default ADDR_W/AFULL_LVL constants in the shared FIFO package, for reuse by the read-side controller.
REQ-031 SHALL instantiate gen_gray_counter (WIDTH=ADDR_W+1, enable=wr_en) as its only sub-module for the write pointer.
REQ-032 SHALL have an RTL size of 120-400 lines and exclude the RAM.

Verification (ADDR_W=4, AFULL_LVL=12)
REQ-033 SHALL cover: 16 back-to-back writes with rd_ptr_gray=0 -> wr_addr 0..15, full=1 after the 16th, almost_full=1 from level 12, wr_level=16.
REQ-034 SHALL cover: writing while full -> wr_en=0, pointer unchanged, ovf_err=1 next cycle and sticky; err_clr then clears it.
REQ-035 SHALL cover: from full, rd_ptr_gray stepped to Gray(1) -> full drops exactly 2 cycles later and wr_level=15.
REQ-036 SHALL cover: 40 writes with the read pointer tracking -> correct wr_addr wrap 15->0, the pointer MSB toggles every 16 writes, and wr_ptr_gray changes one bit per step.
REQ-037 SHALL cover: reset asserted asynchronously mid-burst -> all outputs 0 immediately, and the first write after release uses wr_addr 0.
REQ-038 SHALL cover: err_clr and an overflow on the same cycle -> ovf_err remains 1.
